// File: rtl/decoder_pkg.sv
// ---------------------------------------------------------------------------
// decoder_pkg
// Shared widths, types and the one-hot helper for the 3-to-8 decoder.
//   DEC_IN_W     : width of the binary select index (3)
//   DEC_OUT_W    : width of the one-hot result (8)
//   dec_sel_t    : binary select type
//   dec_onehot_t : one-hot result type
//   onehot3(sel) : returns a vector with only bit 'sel' set
// ---------------------------------------------------------------------------
package decoder_pkg;

    localparam int DEC_IN_W  = 3;
    localparam int DEC_OUT_W = 8;

    typedef logic [DEC_IN_W-1:0]  dec_sel_t;
    typedef logic [DEC_OUT_W-1:0] dec_onehot_t;

    function automatic dec_onehot_t onehot3(input dec_sel_t sel);
        return dec_onehot_t'(1) << sel;
    endfunction

endpackage : decoder_pkg

// File: rtl/decoder_3_to_8.sv
// ---------------------------------------------------------------------------
// decoder_3_to_8
// Registered 3-to-8 one-hot decoder with an active-low enable. The output
// comes straight from flops so downstream selects see a glitch-free,
// clock-aligned one-hot value.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous reset, active-low; clears out immediately
//   in    : 3-bit binary select index
//   en    : enable, active-low (0 = decode, 1 = force out to zero)
//   out   : registered one-hot result, one cycle after in/en are sampled
// ---------------------------------------------------------------------------
module decoder_3_to_8
    import decoder_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DEC_IN_W-1:0]  in,
    input  logic                 en,
    output logic [DEC_OUT_W-1:0] out
);

    dec_onehot_t out_d;
    dec_onehot_t out_q;

    always_comb begin
        out_d = '0;
        if (!en) begin
            out_d = onehot3(in);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

    // Simulation checks on the registered output.
    a_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(out_q));

    a_disabled_zero : assert property (@(posedge clk) disable iff (!rst_n)
        en |=> (out_q == '0));

    a_reset_zero : assert property (@(posedge clk)
        !rst_n |-> (out_q == '0));

endmodule : decoder_3_to_8

// File: tb/tb_decoder_3_to_8.sv
// ---------------------------------------------------------------------------
// tb_decoder_3_to_8
// Self-checking bench for decoder_3_to_8. Inputs change on the falling edge;
// the expected result is queued when inputs are driven and popped one
// rising edge later, sampled 1 ns after that edge.
// ---------------------------------------------------------------------------
module tb_decoder_3_to_8;

    logic       clk;
    logic       rst_n;
    logic [2:0] in;
    logic       en;
    logic [7:0] out;

    int n_checks;
    int n_fails;

    logic [7:0] exp_q[$];

    // Reference one-hot table, written out independently of the RTL.
    logic [7:0] ref_tbl [8];

    decoder_3_to_8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in),
        .en    (en),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] got,
                             input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] model(input logic [2:0] i, input logic e);
        return e ? 8'h00 : ref_tbl[i];
    endfunction

    // Drive one input pair, then compare the output after the next rising edge.
    task automatic step(input string tag, input logic [2:0] i, input logic e);
        logic [7:0] exp;
        @(negedge clk);
        in = i;
        en = e;
        exp_q.push_back(model(i, e));
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_val({tag, "_queue_empty"}, out, 8'hxx);
        end else begin
            exp = exp_q.pop_front();
            check_val(tag, out, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] exp;
        ref_tbl[0] = 8'h01; ref_tbl[1] = 8'h02; ref_tbl[2] = 8'h04; ref_tbl[3] = 8'h08;
        ref_tbl[4] = 8'h10; ref_tbl[5] = 8'h20; ref_tbl[6] = 8'h40; ref_tbl[7] = 8'h80;
        n_checks = 0;
        n_fails  = 0;

        // Asynchronous reset before any clock edge.
        rst_n = 1'b1;
        en    = 1'b0;
        in    = 3'b101;
        #1 rst_n = 1'b0;
        #1 check_val("reset_async", out, 8'h00);
        // Held through running clock edges.
        repeat (2) @(posedge clk);
        #1 check_val("reset_held", out, 8'h00);
        // Release between edges: out must not change on its own.
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_val("reset_release_no_change", out, 8'h00);
        exp_q.push_back(model(3'b101, 1'b0));
        @(posedge clk);
        #1;
        exp = exp_q.pop_front();
        check_val("reset_first_edge", out, exp);

        // Full enabled sweep up to 6, with a mid-stream reset at in=6.
        for (int k = 0; k < 7; k++) step($sformatf("sweep_%0d", k), 3'(k), 1'b0);
        #2 rst_n = 1'b0;
        #1 check_val("midreset_async", out, 8'h00);
        exp_q.delete();
        #2 rst_n = 1'b1;
        #1 check_val("midreset_release_no_change", out, 8'h00);
        exp_q.push_back(model(in, en));
        @(posedge clk);
        #1;
        exp = exp_q.pop_front();
        check_val("midreset_recover", out, exp);
        step("sweep_7", 3'd7, 1'b0);

        // Disabled: output forced to zero regardless of in.
        step("dis_000", 3'b000, 1'b1);
        step("dis_011", 3'b011, 1'b1);
        step("dis_111", 3'b111, 1'b1);

        // Enable toggle with in held at 3.
        step("tog_en0", 3'b011, 1'b0);
        step("tog_en1", 3'b011, 1'b1);
        step("tog_en0b", 3'b011, 1'b0);

        // Random in/en.
        for (int r = 0; r < 1000; r++)
            step("random", 3'($urandom_range(7)), 1'($urandom_range(1)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_decoder_3_to_8
